fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I pipeline; directly upstream of decode and the primary consumer of the hazard unit's `stall_if`, `stall_id`, `flush_id` and `pc_src_ex`. It holds the PC, runs a one-outstanding-request handshake with instruction memory, buffers one returned word while decode is stalled, and drops stale responses after an EX-stage redirect. It drives `instr_id`/`pc_id`/`pc_plus4_id`/`valid_id` to decode.

## Interface
- `RESET_PC`, 32'h0000_0000, PC after reset.
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (addi x0,x0,0).

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall_if` in 1: hold PC; do not issue a new request.
- `stall_id` in 1: hold the IF/ID register.
- `flush_id` in 1: load a bubble into IF/ID.
- `pc_src_ex` in 1: redirect taken in EX.
- `pc_target_ex` in 32: redirect target; bits [1:0] are ignored and forced to 0.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: request address, word aligned.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid.
- `imem_rdata` in 32: response instruction.
- `instr_id` out 32: IF/ID instruction.
- `pc_id` out 32: IF/ID PC.
- `pc_plus4_id` out 32: `pc_id` + 4, mod 2^32.
- `valid_id` out 1: IF/ID holds a real instruction.
- `perf_instr_cnt` out 32: instructions delivered to decode.
- `perf_bubble_cnt` out 32: starvation bubbles.

## Operation
- Registers:
  - `pc_f`: address of the oldest unconsumed instruction.
  - FSM `state` ∈ {REQ, WAIT, DROP}.
  - Skid: `skid_valid`, `skid_instr`.
  - IF/ID registers.
- REQ: `imem_req = !stall_if && !skid_valid`; `imem_addr = pc_f`. On `imem_req && imem_gnt` → WAIT.
- WAIT: awaiting the response for `pc_f`. On `imem_rvalid` the word is *available*. If it is not consumed this cycle, it goes into the skid buffer. → REQ.
- DROP: the next `imem_rvalid` is discarded. → REQ. No request is issued in DROP.
- Available word = skid entry if `skid_valid`, else `imem_rdata` when in WAIT with `imem_rvalid`.
- IF/ID update, highest priority first:
  1. `flush_id`: load bubble.
  2. `stall_id`: hold.
  3. Available word present: load {word, `pc_f`}, set `valid_id=1`, `pc_f += 4`, clear skid.
  4. Otherwise: load bubble and increment the bubble counter.
- Bubble = `instr_id=NOP_INSTR`, `pc_id=0`, `pc_plus4_id=4`, `valid_id=0`.
- Redirect (`pc_src_ex=1`) overrides every PC/skid/FSM update above:
  - `pc_f <= {pc_target_ex[31:2],2'b00}`; skid cleared.
  - In WAIT without `imem_rvalid` → DROP.
  - In WAIT with `imem_rvalid` → response discarded, → REQ.
  - In REQ with `imem_req && imem_gnt` → DROP.
  - Otherwise → REQ.
- `imem_rvalid` in REQ is ignored.
- Instruction memory must be reset together with this block.
- `stall_if` without `stall_id`: no new request; a pending response may still be consumed.

## Timing
- Reset values:
  - `pc_f=RESET_PC`, state REQ, `skid_valid=0`.
  - IF/ID holds a bubble; perf counters 0.
  - `imem_req=0` while `rst=1`.
- `imem_req`/`imem_addr` are combinational from registered state, `skid_valid` and `stall_if` only. There is no path from `imem_gnt`/`imem_rvalid`.
- Latency: `imem_rvalid` in cycle N → `instr_id` valid at N+1 (if not stalled).
- Next request is issued at N+1. Peak throughput is 1 instruction per 2 cycles with a zero-wait memory (`gnt` same cycle, `rvalid` next cycle).
- At most one request is outstanding, and at most one word is buffered.
- `pc_src_ex` and `stall_id` in the same cycle: redirect and flush take effect; no hold.
- `rst` mid-transaction: all state returns to reset values on the next edge.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `perf_instr_cnt` increments on each IF/ID load with `valid_id=1`.
  - `perf_bubble_cnt` increments on each starvation bubble (case 4; not on flush or hold).
  - Both are 32-bit, wrap at 2^32 and clear on `rst`.
- Not defined: both outputs are tied to 0 and no counter logic is generated. The port list is unchanged.

## Test plan
- **Reset:** `RESET_PC=0x100`, hold `rst` 2 cycles. Required: `imem_req=0` during reset; after release `imem_req=1`, `imem_addr=0x100`; `instr_id=0x13`, `valid_id=0`.
- **Zero-wait fetch:** `gnt=1`, `rvalid` 1 cycle later with data 0x00500093. Required: next cycle `instr_id=0x00500093`, `pc_id=0x100`, `pc_plus4_id=0x104`, `valid_id=1`; the following request has `imem_addr=0x104`.
- **Stall with response:** `rvalid` arrives with `stall_id=stall_if=1` for 3 cycles. Required: IF/ID held; `imem_req=0` throughout; the word appears in `instr_id` on the cycle after the stall drops, then the next request issues.
- **Redirect while WAIT:** `pc_src_ex=1`, `pc_target_ex=0x203`, `flush_id=1`; stale `rvalid` 2 cycles later. Required: stale word dropped; `valid_id=0`; next `imem_addr=0x200`.
- **Redirect + stall:** `pc_src_ex=flush_id=stall_id=1` together. Required: bubble loaded (`valid_id=0`); `pc_f=target`.
- **Perf counters:** with `FETCH_PERF_CNT_EN`, 1-wait memory, 10 instructions. Required: `perf_instr_cnt=10`, `perf_bubble_cnt` equals the counted starvation cycles. Without the macro: both read 0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage and IF/ID pipeline register.
// Keeps one request outstanding to instruction memory. Holds one returned word
// in a skid buffer while decode is stalled. Drops responses that are stale
// because of an EX-stage redirect.
// Optional feature: define FETCH_PERF_CNT_EN to build the instruction and
// starvation-bubble performance counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_if,
   input  logic        stall_id,
   input  logic        flush_id,
   input  logic        pc_src_ex,
   input  logic [31:0] pc_target_ex,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_id,
   output logic [31:0] pc_id,
   output logic [31:0] pc_plus4_id,
   output logic        valid_id,
   output logic [31:0] perf_instr_cnt,
   output logic [31:0] perf_bubble_cnt
);

   typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_f_q, pc_f_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_instr_q, skid_instr_d;

   logic        avail;
   logic [31:0] avail_word;
   logic        consume;
   logic        starve;
   logic [31:0] target_aligned;

   assign target_aligned = pc_target_ex & 32'hFFFF_FFFC;

   // Request side: depends only on registered state, skid and stall_if.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = pc_f_q;
      if (!rst && state_q == StReq && !stall_if && !skid_valid_q) begin
         imem_req = 1'b1;
      end
   end

   // Word available to decode this cycle, and whether IF/ID takes it.
   always_comb begin
      avail      = skid_valid_q || (state_q == StWait && imem_rvalid);
      avail_word = skid_valid_q ? skid_instr_q : imem_rdata;
      consume    = !flush_id && !stall_id && avail;
      starve     = !flush_id && !stall_id && !avail;
   end

   // Next-state for FSM, PC and skid buffer; a redirect overrides everything.
   always_comb begin
      state_d      = state_q;
      pc_f_d       = pc_f_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      unique case (state_q)
         StReq: begin
            if (imem_req && imem_gnt) state_d = StWait;
         end
         StWait: begin
            if (imem_rvalid) begin
               state_d = StReq;
               if (!consume) begin
                  skid_valid_d = 1'b1;
                  skid_instr_d = imem_rdata;
               end
            end
         end
         StDrop: begin
            if (imem_rvalid) state_d = StReq;
         end
         default: state_d = StReq;
      endcase
      if (consume) begin
         pc_f_d       = pc_f_q + 32'd4;
         skid_valid_d = 1'b0;
      end
      if (pc_src_ex) begin
         pc_f_d       = target_aligned;
         skid_valid_d = 1'b0;
         // A granted request whose response has not yet returned must be dropped.
         if ((state_q == StWait && !imem_rvalid) || (state_q == StReq && imem_req && imem_gnt)) begin
            state_d = StDrop;
         end else begin
            state_d = StReq;
         end
      end
   end

   // FSM, PC and skid registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StReq;
         pc_f_q       <= RESET_PC;
         skid_valid_q <= 1'b0;
         skid_instr_q <= NOP_INSTR;
      end else begin
         state_q      <= state_d;
         pc_f_q       <= pc_f_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
      end
   end

   // IF/ID register: flush > hold > load available word > starvation bubble.
   always_ff @(posedge clk) begin
      if (rst || flush_id) begin
         instr_id <= NOP_INSTR;
         pc_id    <= 32'd0;
         valid_id <= 1'b0;
      end else if (stall_id) begin
         instr_id <= instr_id;
         pc_id    <= pc_id;
         valid_id <= valid_id;
      end else if (avail) begin
         instr_id <= avail_word;
         pc_id    <= pc_f_q;
         valid_id <= 1'b1;
      end else begin
         instr_id <= NOP_INSTR;
         pc_id    <= 32'd0;
         valid_id <= 1'b0;
      end
   end

   assign pc_plus4_id = pc_id + 32'd4;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] instr_cnt_q, bubble_cnt_q;

   // Delivered-instruction and starvation-bubble counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_cnt_q  <= 32'd0;
         bubble_cnt_q <= 32'd0;
      end else begin
         if (consume) instr_cnt_q <= instr_cnt_q + 32'd1;
         if (starve)  bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign perf_instr_cnt  = instr_cnt_q;
   assign perf_bubble_cnt = bubble_cnt_q;
`else
   logic unused_perf;
   assign unused_perf     = starve;
   assign perf_instr_cnt  = 32'd0;
   assign perf_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with hand-computed expectations.
// Honours FETCH_PERF_CNT_EN when checking the performance counters.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_if, stall_id, flush_id, pc_src_ex;
   logic [31:0] pc_target_ex;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt, imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr_id, pc_id, pc_plus4_id;
   logic        valid_id;
   logic [31:0] perf_instr_cnt, perf_bubble_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fetch_stage #(
      .RESET_PC  (32'h0000_0100),
      .NOP_INSTR (32'h0000_0013)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_if        (stall_if),
      .stall_id        (stall_id),
      .flush_id        (flush_id),
      .pc_src_ex       (pc_src_ex),
      .pc_target_ex    (pc_target_ex),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_gnt        (imem_gnt),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .instr_id        (instr_id),
      .pc_id           (pc_id),
      .pc_plus4_id     (pc_plus4_id),
      .valid_id        (valid_id),
      .perf_instr_cnt  (perf_instr_cnt),
      .perf_bubble_cnt (perf_bubble_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // Advance past the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp_instr_cnt;
      logic [31:0] exp_bubble_cnt;
      logic [31:0] last_word;

      rst = 1'b1; stall_if = 0; stall_id = 0; flush_id = 0; pc_src_ex = 0;
      pc_target_ex = 32'd0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'd0;
      last_word = 32'd0;

      // Reset.
      #1;
      check_eq("req_in_reset0", {31'd0, imem_req}, 32'd0);
      cyc();
      cyc();
      check_eq("req_in_reset1", {31'd0, imem_req}, 32'd0);
      check_eq("reset_instr", instr_id, 32'h13);
      check_eq("reset_valid", {31'd0, valid_id}, 32'd0);
      rst = 1'b0;
      #1;
      check_eq("reset_req", {31'd0, imem_req}, 32'd1);
      check_eq("reset_addr", imem_addr, 32'h100);

      // Zero-wait fetch.
      imem_gnt = 1; cyc();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0050_0093; #1;
      check_eq("wait_no_req", {31'd0, imem_req}, 32'd0);
      cyc();
      imem_rvalid = 0; #1;
      check_eq("zw_instr", instr_id, 32'h0050_0093);
      check_eq("zw_pc", pc_id, 32'h100);
      check_eq("zw_pc4", pc_plus4_id, 32'h104);
      check_eq("zw_valid", {31'd0, valid_id}, 32'd1);
      check_eq("zw_next_req", {31'd0, imem_req}, 32'd1);
      check_eq("zw_next_addr", imem_addr, 32'h104);

      // Stall with a response arriving.
      imem_gnt = 1; cyc();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00A0_0113;
      stall_if = 1; stall_id = 1; #1;
      check_eq("st_req0", {31'd0, imem_req}, 32'd0);
      cyc();
      imem_rvalid = 0; #1;
      check_eq("st_req1", {31'd0, imem_req}, 32'd0);
      check_eq("st_hold1", {31'd0, valid_id}, 32'd0);
      cyc();
      check_eq("st_req2", {31'd0, imem_req}, 32'd0);
      check_eq("st_hold2", instr_id, 32'h13);
      cyc();
      stall_if = 0; stall_id = 0; #1;
      check_eq("st_skid_blocks_req", {31'd0, imem_req}, 32'd0);
      cyc();
      check_eq("st_instr", instr_id, 32'h00A0_0113);
      check_eq("st_pc", pc_id, 32'h104);
      check_eq("st_valid", {31'd0, valid_id}, 32'd1);
      check_eq("st_next_req", {31'd0, imem_req}, 32'd1);
      check_eq("st_next_addr", imem_addr, 32'h108);

      // Redirect while waiting; stale response two cycles later.
      imem_gnt = 1; cyc();
      imem_gnt = 0; pc_src_ex = 1; pc_target_ex = 32'h203; flush_id = 1; cyc();
      pc_src_ex = 0; flush_id = 0; #1;
      check_eq("rd_drop_no_req", {31'd0, imem_req}, 32'd0);
      cyc();
      imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; #1;
      check_eq("rd_drop_no_req2", {31'd0, imem_req}, 32'd0);
      cyc();
      imem_rvalid = 0; #1;
      check_eq("rd_valid", {31'd0, valid_id}, 32'd0);
      check_eq("rd_instr", instr_id, 32'h13);
      check_eq("rd_req", {31'd0, imem_req}, 32'd1);
      check_eq("rd_addr", imem_addr, 32'h200);

      // Fetch at 0x200, hold it, then redirect+flush+stall together.
      imem_gnt = 1; cyc();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0010_0193; cyc();
      imem_rvalid = 0; #1;
      check_eq("rs_pre_pc", pc_id, 32'h200);
      check_eq("rs_pre_valid", {31'd0, valid_id}, 32'd1);
      imem_gnt = 1; stall_id = 1; cyc();
      imem_gnt = 0; pc_src_ex = 1; flush_id = 1; pc_target_ex = 32'h300;
      imem_rvalid = 1; imem_rdata = 32'h1111_1111; cyc();
      pc_src_ex = 0; flush_id = 0; stall_id = 0; imem_rvalid = 0; #1;
      check_eq("rs_valid", {31'd0, valid_id}, 32'd0);
      check_eq("rs_instr", instr_id, 32'h13);
      check_eq("rs_pc", pc_id, 32'h0);
      check_eq("rs_pc4", pc_plus4_id, 32'h4);
      check_eq("rs_req", {31'd0, imem_req}, 32'd1);
      check_eq("rs_addr", imem_addr, 32'h300);
`ifdef FETCH_PERF_CNT_EN
      exp_instr_cnt = 32'd3; exp_bubble_cnt = 32'd6;
`else
      exp_instr_cnt = 32'd0; exp_bubble_cnt = 32'd0;
`endif
      check_eq("perf_instr_a", perf_instr_cnt, exp_instr_cnt);
      check_eq("perf_bubble_a", perf_bubble_cnt, exp_bubble_cnt);

      // Mid-stream reset, then 10 instructions from a 1-wait memory.
      rst = 1; cyc();
      rst = 0;
      for (int i = 0; i < 10; i++) begin
         imem_gnt = 1; #1;
         check_eq("pf_req", {31'd0, imem_req}, 32'd1);
         check_eq("pf_addr", imem_addr, 32'h100 + 32'(4 * i));
         cyc();
         imem_gnt = 0; #1;
         check_eq("pf_wait_no_req", {31'd0, imem_req}, 32'd0);
         cyc();
         last_word = 32'h0000_0093 | (32'(i) << 20);
         imem_rvalid = 1; imem_rdata = last_word; cyc();
         imem_rvalid = 0;
      end
      #1;
      check_eq("pf_last_instr", instr_id, last_word);
      check_eq("pf_last_pc", pc_id, 32'h124);
      check_eq("pf_last_valid", {31'd0, valid_id}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
      exp_instr_cnt = 32'd10; exp_bubble_cnt = 32'd20;
`else
      exp_instr_cnt = 32'd0; exp_bubble_cnt = 32'd0;
`endif
      check_eq("perf_instr_b", perf_instr_cnt, exp_instr_cnt);
      check_eq("perf_bubble_b", perf_bubble_cnt, exp_bubble_cnt);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
